// File: rtl/writeback_regfile.sv
// writeback_regfile
// Architectural register file at the end of the writeback stage.
//   - NREG x 32-bit registers; r0 has no storage and always reads zero.
//   - r30 (STATUS_IDX) is rstatus; r31 is the jal link register.
//   - General write port (ctrl_writeEnable/ctrl_writeReg/data_writeReg).
//   - Dedicated status write port (ctrl_writeStatus/data_writeStatusReg)
//     that always targets STATUS_IDX and wins over a general write to it.
//   - Two independent combinational read ports (A, B).
//   - status_exception: registered rstatus[0] as held after each edge.
//   - write_conflict:   registered one-cycle pulse after a status/general
//                       collision on STATUS_IDX.
// Optional feature macro: REGFILE_BYPASS_EN
//   When defined, the read ports forward same-cycle write data
//   (status bypass over general bypass). When undefined, reads see storage only.
//
// Ports
//   clock, resetn                      clock, async active-low reset
//   ctrl_writeEnable, ctrl_writeReg,
//   data_writeReg                      general write port
//   ctrl_writeStatus, data_writeStatusReg  status write port
//   ctrl_readRegA/B, data_readRegA/B   read ports
//   status_exception, write_conflict   registered status outputs

module writeback_regfile #(
  parameter int unsigned NREG       = 32,
  parameter int unsigned STATUS_IDX = 30
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        ctrl_writeEnable,
  input  logic [4:0]  ctrl_writeReg,
  input  logic [31:0] data_writeReg,
  input  logic        ctrl_writeStatus,
  input  logic [31:0] data_writeStatusReg,
  input  logic [4:0]  ctrl_readRegA,
  input  logic [4:0]  ctrl_readRegB,
  output logic [31:0] data_readRegA,
  output logic [31:0] data_readRegB,
  output logic        status_exception,
  output logic        write_conflict
);

  localparam int unsigned IDX_W  = 5;
  localparam int unsigned DATA_W = 32;

  // Storage for r1..r(NREG-1); r0 is hard-wired to zero.
  logic [DATA_W-1:0] regs_q [1:NREG-1];
  logic [DATA_W-1:0] regs_d [1:NREG-1];

  logic status_exception_q, status_exception_d;
  logic write_conflict_q,   write_conflict_d;

  logic gen_wr_c;
  logic status_hit_c;

  logic [DATA_W-1:0] rd_a_c;
  logic [DATA_W-1:0] rd_b_c;

  // Qualified write strobes: destination 0 is dropped silently.
  always_comb begin
    gen_wr_c     = ctrl_writeEnable && (ctrl_writeReg != '0);
    status_hit_c = gen_wr_c && (ctrl_writeReg == IDX_W'(STATUS_IDX));
  end

  // Next-state for storage and registered status outputs.
  always_comb begin
    regs_d             = regs_q;
    status_exception_d = 1'b0;
    write_conflict_d   = ctrl_writeStatus && status_hit_c;

    for (int unsigned i = 1; i < NREG; i++) begin
      if (gen_wr_c && (ctrl_writeReg == IDX_W'(i))) begin
        regs_d[i] = data_writeReg;
      end
      // Status port applied last so it wins a collision on STATUS_IDX.
      if (ctrl_writeStatus && (i == STATUS_IDX)) begin
        regs_d[i] = data_writeStatusReg;
      end
    end

    // Mirror bit 0 of rstatus as it will be after this edge.
    for (int unsigned i = 1; i < NREG; i++) begin
      if (i == STATUS_IDX) begin
        status_exception_d = regs_d[i][0];
      end
    end
  end

  // State registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 1; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      status_exception_q <= 1'b0;
      write_conflict_q   <= 1'b0;
    end else begin
      for (int unsigned i = 1; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
      status_exception_q <= status_exception_d;
      write_conflict_q   <= write_conflict_d;
    end
  end

  // Read port A: storage lookup, optional same-cycle forwarding.
  always_comb begin
    rd_a_c = '0;
    for (int unsigned i = 1; i < NREG; i++) begin
      if (ctrl_readRegA == IDX_W'(i)) begin
        rd_a_c = regs_q[i];
      end
    end
`ifdef REGFILE_BYPASS_EN
    if (ctrl_writeStatus && (ctrl_readRegA == IDX_W'(STATUS_IDX))) begin
      rd_a_c = data_writeStatusReg;
    end else if (gen_wr_c && (ctrl_readRegA == ctrl_writeReg)) begin
      rd_a_c = data_writeReg;
    end
`endif
  end

  // Read port B: identical to port A.
  always_comb begin
    rd_b_c = '0;
    for (int unsigned i = 1; i < NREG; i++) begin
      if (ctrl_readRegB == IDX_W'(i)) begin
        rd_b_c = regs_q[i];
      end
    end
`ifdef REGFILE_BYPASS_EN
    if (ctrl_writeStatus && (ctrl_readRegB == IDX_W'(STATUS_IDX))) begin
      rd_b_c = data_writeStatusReg;
    end else if (gen_wr_c && (ctrl_readRegB == ctrl_writeReg)) begin
      rd_b_c = data_writeReg;
    end
`endif
  end

  // Reads are forced to zero while reset is held, even with forwarding.
  assign data_readRegA    = resetn ? rd_a_c : '0;
  assign data_readRegB    = resetn ? rd_b_c : '0;
  assign status_exception = status_exception_q;
  assign write_conflict   = write_conflict_q;

endmodule

// File: tb/tb_writeback_regfile.sv
module tb_writeback_regfile;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        resetn;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        ctrl_writeStatus;
  logic [31:0] data_writeStatusReg;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic [31:0] data_readRegA;
  logic [31:0] data_readRegB;
  logic        status_exception;
  logic        write_conflict;

  writeback_regfile dut (
    .clock               (clock),
    .resetn              (resetn),
    .ctrl_writeEnable    (ctrl_writeEnable),
    .ctrl_writeReg       (ctrl_writeReg),
    .data_writeReg       (data_writeReg),
    .ctrl_writeStatus    (ctrl_writeStatus),
    .data_writeStatusReg (data_writeStatusReg),
    .ctrl_readRegA       (ctrl_readRegA),
    .ctrl_readRegB       (ctrl_readRegB),
    .data_readRegA       (data_readRegA),
    .data_readRegB       (data_readRegB),
    .status_exception    (status_exception),
    .write_conflict      (write_conflict)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Scoreboard: parallel queues of expected observations tagged by cycle.
  string       nm_q[$];
  int          cyc_q[$];
  int          kind_q[$];
  logic [31:0] exp_q[$];

  event mid_ev;

  task automatic push(input string nm, input int kind, input logic [31:0] v);
    nm_q.push_back(nm);
    cyc_q.push_back(cyc);
    kind_q.push_back(kind);
    exp_q.push_back(v);
  endtask

  task automatic expect_all(input string nm, input logic [31:0] a, input logic [31:0] b,
                            input logic exc, input logic conf);
    push({nm, ".rdA"}, 0, a);
    push({nm, ".rdB"}, 1, b);
    push({nm, ".exc"}, 2, 32'(exc));
    push({nm, ".conf"}, 3, 32'(conf));
  endtask

  // Monitor: samples on the falling edge (or a mid-cycle event) and retires
  // every expectation tagged for the current cycle.
  initial begin
    string       nm;
    int          kind;
    logic [31:0] ev, act;
    forever begin
      @(negedge clock or mid_ev);
      while (cyc_q.size() > 0 && cyc_q[0] <= cyc) begin
        nm   = nm_q.pop_front();
        kind = kind_q.pop_front();
        ev   = exp_q.pop_front();
        if (cyc_q.pop_front() < cyc) begin
          tests++;
          fails++;
          $display("FAIL %s: expectation not sampled in its cycle (want %h)", nm, ev);
        end else begin
          case (kind)
            0:       act = data_readRegA;
            1:       act = data_readRegB;
            2:       act = 32'(status_exception);
            default: act = 32'(write_conflict);
          endcase
          tests++;
          if (act !== ev) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, ev);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic ws, input logic [31:0] sd,
                       input logic [4:0] ra, input logic [4:0] rb);
    ctrl_writeEnable    = we;
    ctrl_writeReg       = wr;
    data_writeReg       = wd;
    ctrl_writeStatus    = ws;
    data_writeStatusReg = sd;
    ctrl_readRegA       = ra;
    ctrl_readRegB       = rb;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd0, 5'd0);

    // Reset held: sweep all indices with writes presented; everything reads 0.
    for (int i = 0; i < 32; i++) begin
      step();
      drive(1'b1, 5'd5, 32'hFFFF_FFFF, 1'b1, 32'h1, 5'(i), 5'(31 - i));
      expect_all("reset_sweep", 32'h0, 32'h0, 1'b0, 1'b0);
    end

    step(); resetn = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd5, 5'd30);
    expect_all("post_reset", 32'h0, 32'h0, 1'b0, 1'b0);

    step(); drive(1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 32'h0, 5'd0, 5'd0);
    expect_all("r0_write", 32'h0, 32'h0, 1'b0, 1'b0);
    step(); drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd0, 5'd0);
    expect_all("r0_read", 32'h0, 32'h0, 1'b0, 1'b0);

    step(); drive(1'b1, 5'd5, 32'h1234, 1'b0, 32'h0, 5'd5, 5'd0);
    expect_all("r5_write", BYP ? 32'h1234 : 32'h0, 32'h0, 1'b0, 1'b0);
    step(); drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd5, 5'd0);
    expect_all("r5_read", 32'h1234, 32'h0, 1'b0, 1'b0);

    step(); drive(1'b1, 5'd31, 32'h42, 1'b0, 32'h0, 5'd31, 5'd31);
    expect_all("jal_write", BYP ? 32'h42 : 32'h0, BYP ? 32'h42 : 32'h0, 1'b0, 1'b0);
    step(); drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd31, 5'd31);
    expect_all("jal_read", 32'h42, 32'h42, 1'b0, 1'b0);

    step(); drive(1'b1, 5'd30, 32'h7, 1'b1, 32'h1, 5'd30, 5'd30);
    expect_all("collide_write", BYP ? 32'h1 : 32'h0, BYP ? 32'h1 : 32'h0, 1'b0, 1'b0);
    step(); drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd30, 5'd30);
    expect_all("collide_read", 32'h1, 32'h1, 1'b1, 1'b1);
    step(); drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd30, 5'd31);
    expect_all("collide_pulse_end", 32'h1, 32'h42, 1'b1, 1'b0);

    step(); drive(1'b1, 5'd3, 32'hA5A5A5A5, 1'b1, 32'h0, 5'd3, 5'd30);
    expect_all("parallel_write", BYP ? 32'hA5A5A5A5 : 32'h0, BYP ? 32'h0 : 32'h1, 1'b1, 1'b0);
    step(); drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd3, 5'd30);
    expect_all("parallel_read", 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0);

    step(); drive(1'b1, 5'd9, 32'h11111111, 1'b0, 32'h0, 5'd0, 5'd9);
    expect_all("r9_old", 32'h0, BYP ? 32'h11111111 : 32'h0, 1'b0, 1'b0);
    step(); drive(1'b1, 5'd9, 32'hCAFEF00D, 1'b0, 32'h0, 5'd9, 5'd9);
    expect_all("bypass_same", BYP ? 32'hCAFEF00D : 32'h11111111,
               BYP ? 32'hCAFEF00D : 32'h11111111, 1'b0, 1'b0);
    step(); drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd5, 5'd9);
    expect_all("bypass_next", 32'h1234, 32'hCAFEF00D, 1'b0, 1'b0);

    step(); drive(1'b1, 5'd7, 32'h77, 1'b0, 32'h0, 5'd7, 5'd3);
    expect_all("r7_write", BYP ? 32'h77 : 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0);
    step(); drive(1'b1, 5'd30, 32'h5, 1'b1, 32'h1, 5'd7, 5'd30);
    expect_all("collide2", 32'h77, BYP ? 32'h1 : 32'h0, 1'b0, 1'b0);
    step(); drive(1'b1, 5'd7, 32'h88, 1'b0, 32'h0, 5'd7, 5'd30);
    expect_all("pre_async", BYP ? 32'h88 : 32'h77, 32'h1, 1'b1, 1'b1);

    // Assert reset between edges; outputs must clear before the next edge.
    @(negedge clock); #1;
    resetn = 1'b0;
    #1;
    expect_all("async_reset", 32'h0, 32'h0, 1'b0, 1'b0);
    -> mid_ev;

    step(); resetn = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd7, 5'd30);
    expect_all("discarded_write", 32'h0, 32'h0, 1'b0, 1'b0);
    step(); drive(1'b1, 5'd7, 32'h99, 1'b0, 32'h0, 5'd0, 5'd0);
    expect_all("first_write", 32'h0, 32'h0, 1'b0, 1'b0);
    step(); drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd7, 5'd7);
    expect_all("first_read", 32'h99, 32'h99, 1'b0, 1'b0);

    step();
    step();
    if (cyc_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", cyc_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/writeback_regfile.md
# writeback_regfile

Architectural register file that terminates the writeback stage. It accepts the per-cycle general write (`data_writeReg`) and the dedicated status write (`data_writeStatusReg`). It holds 32 x 32-bit registers and serves two combinational read ports to decode. Register 0 reads as zero, r30 is `rstatus`, and r31 is the link register written by `jal`.

## Interface
- `NREG`, default 32: number of architectural registers; index width is fixed at 5.
- `STATUS_IDX`, default 30: index of `rstatus`.
- `clock` in 1: single clock; all writes occur on its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `ctrl_writeEnable` in 1: general write strobe from writeback.
- `ctrl_writeReg` in 5: general write destination.
- `data_writeReg` in 32: general write data.
- `ctrl_writeStatus` in 1: status write strobe (exception-capable ops, `setx`).
- `data_writeStatusReg` in 32: status write data, always targets `STATUS_IDX`.
- `ctrl_readRegA` in 5: read port A index.
- `ctrl_readRegB` in 5: read port B index.
- `data_readRegA` out 32: read port A data.
- `data_readRegB` out 32: read port B data.
- `status_exception` out 1: registered copy of `rstatus[0]`.
- `write_conflict` out 1: one-cycle pulse, registered, set when both strobes targeted `STATUS_IDX` in the previous cycle.

## Operation
- Storage holds registers 1..31 as flops. Register 0 has no storage; reads of index 0 return 32'h0 regardless of any write.
- General write: on a rising edge with `ctrl_writeEnable`=1 and `ctrl_writeReg`!=0, the register at `ctrl_writeReg` takes `data_writeReg`. Writes with destination 0 are discarded silently.
- Status write: on a rising edge with `ctrl_writeStatus`=1, register `STATUS_IDX` takes `data_writeStatusReg`.
- Simultaneous status and general writes:
  - Different destinations: both writes commit in the same edge.
  - Both targeting `STATUS_IDX`: the status port wins, and the general write to r30 is dropped.
  - Same conflict case: `write_conflict` asserts for exactly the next cycle.
- `status_exception` is updated on every edge to the bit-0 value r30 holds after that edge. It therefore mirrors `rstatus[0]` with zero extra latency relative to storage.
- Reads are purely combinational from storage, plus bypass when configured (see Configuration). A read index is never range-checked because all 32 indices are legal.
- Reset:
  - `resetn` low immediately clears all registers, `status_exception`, and `write_conflict` to 0, independent of `clock`.
  - Read outputs show 0 for every index while reset is held.
  - Reset asserted mid-cycle discards any write that would have occurred on the next edge.
  - Deassertion is treated as synchronous to `clock` by the upstream reset synchroniser, and the first write is accepted on the first edge after release.

## Timing
- Write latency: the value is architecturally visible from storage one edge after the strobe.
- Read latency: combinational, zero cycles. Both read ports are independent and may address the same register.
- `write_conflict` and `status_exception` are registered outputs with no combinational path from inputs.
- There is no back-pressure and no handshake. Every strobe presented at an edge is consumed.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - If a read index equals the active general-write destination (nonzero) in the same cycle, the read port returns `data_writeReg`.
  - If the read index equals `STATUS_IDX` with `ctrl_writeStatus`=1, the read port returns `data_writeStatusReg`.
  - Status bypass has priority over general bypass, matching commit priority.
  - The result is write-before-read semantics within one cycle.
- `REGFILE_BYPASS_EN` undefined:
  - Reads return storage only, so a same-cycle write becomes visible one cycle later.
  - The hazard unit must stall one extra cycle to cover this.

## Test plan
- Reset: hold `resetn`=0, sweep read indices 0..31 -> all reads 0, `status_exception`=0, `write_conflict`=0. Assert reset asynchronously between edges after writes -> outputs go 0 before the next edge.
- r0 immunity: write 32'hDEADBEEF to index 0 -> the next cycle reads 0 on both ports. Write 32'h1234 to r5 -> the next cycle port A reads 32'h1234.
- jal link: general write of 32'h00000042 to r31 -> the next cycle reads 32'h42 on both ports with A=B=31.
- Status/general collision: the same edge has status data 32'h1 and general write of 32'h7 to r30 -> r30 reads 32'h1, `status_exception`=1, `write_conflict` pulses for exactly one cycle.
- Parallel writes: status 32'h0 and general 32'hA5A5A5A5 to r3 on the same edge -> r3 reads 32'hA5A5A5A5, r30 reads 0, no conflict pulse.
- Bypass: write 32'hCAFEF00D to r9 while port B reads r9 -> with `REGFILE_BYPASS_EN` defined, B shows 32'hCAFEF00D that same cycle. Without it, B shows the old value, then 32'hCAFEF00D the next cycle.
